wave_sequencer: RTL and testbench
=================================

# wave_sequencer

Run controller for the waveform ROM bank: a phase-accumulator DDS front end that generates the 8-bit phase, waveform select and ROM enable, and flags valid amplitude samples. It sits between the host/register side and the ROM, takes a configuration (tuning word, waveform, burst length) over a valid/ready handshake, and applies waveform changes only at phase wrap so output periods are never cut mid-cycle.

## Interface
- ACC_W, 32, phase accumulator width
- PHASE_W, 8, phase output width (top bits of accumulator)
- CNT_W, 16, burst period counter width
- ROM_LAT, 2, clocks from rom_en rising (or select change) to valid ROM amplitude
- clk  in  1  system clock, rising edge
- en  in  1  asynchronous, active-low reset
- start  in  1  begin a run (sampled in IDLE only)
- stop  in  1  request graceful end at next phase wrap
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration can be accepted
- cfg_fword  in  ACC_W  frequency tuning word
- cfg_select  in  2  00 tri, 01 reverse tri, 10 square, 11 cosine
- cfg_cycles  in  CNT_W  periods per burst; 0 = continuous
- rom_en  out  1  ROM enable
- rom_select  out  2  ROM waveform select
- rom_phase  out  PHASE_W  ROM phase/address
- amp_valid  out  1  ROM amplitude this cycle is a valid sample
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on return to IDLE

## Operation
- Reset (en low): all outputs 0; acc, counters, active and shadow config cleared; state IDLE. Takes effect immediately, mid-run included.
- Config handshake: transfer when cfg_valid && cfg_ready. In IDLE cfg_ready=1; transfer loads active config directly. In PRIME/RUN transfer loads shadow and sets pending; cfg_ready=0 while pending. In DRAIN cfg_ready=0.
- States: IDLE, PRIME, RUN, DRAIN.
- IDLE -> PRIME on start. Config transferred in the same cycle as start is used for the run. acc cleared, remaining <= cfg_cycles, rom_en=1.
- PRIME: acc advances (acc <= acc + fword, modulo 2^ACC_W); lasts ROM_LAT cycles, then RUN.
- RUN: acc advances each cycle. Wrap = carry out of the add.
- On wrap: if pending, active <= shadow, pending cleared (new fword used from next add). If cycles != 0, remaining decrements; reaching 0 -> DRAIN. If stop_req set -> DRAIN.
- stop in PRIME/RUN sets stop_req, cleared in IDLE. If active fword == 0 (no wrap possible), stop_req -> DRAIN next cycle.
- DRAIN: acc frozen, rom_en held for ROM_LAT cycles, then rom_en=0, done=1 for one cycle, IDLE.
- start outside IDLE ignored. Wrap with stop_req and pending config: config applied, then DRAIN.

## Timing
- rom_phase = acc[ACC_W-1 -: PHASE_W], registered; rom_select = active select, registered.
- amp_valid = rom_en delayed ROM_LAT cycles, forced 0 the cycle rom_en is 0.
- On select change at wrap: amp_valid = 0 for ROM_LAT cycles starting the cycle after the change.
- First valid sample: start at edge t -> rom_en high after t, amp_valid high after t+ROM_LAT.
- Width: tuning add truncates to ACC_W; remaining never underflows (0 means continuous, not decremented).

## Structure
- Shared package: waveform select constants (WAVE_TRI, WAVE_TRI_REV, WAVE_SQUARE, WAVE_COS), state encoding, default parameter values.
- One sub-module natural: phase_accum (accumulator, carry-out wrap flag, freeze input). FSM, handshake and valid pipeline stay in wave_sequencer.

## Test plan
- Reset/idle: en low mid-RUN with fword 0x0100_0000 -> all outputs 0 immediately; cfg_ready=1 after release.
- Burst: fword 0x0100_0000, select 11, cycles 2, start -> amp_valid from t+2, rom_phase 0..255 twice (512 RUN+PRIME advances), DRAIN 2 cycles, done one pulse, busy low.
- Continuous + stop: cycles 0, fword 0x0400_0000, stop at phase 0x20 -> continues to wrap (phase 0xFC -> wrap), DRAIN, done.
- Glitch-free change: RUN select 00, offer select 10 mid-period -> cfg_ready drops, rom_select changes exactly on wrap, amp_valid low 2 cycles, cfg_ready returns.
- Zero fword: fword 0, start, stop -> rom_phase stays 0, DRAIN entered next cycle, done after 2 cycles.
- Simultaneous: cfg transfer and start same cycle in IDLE -> run uses new fword/select; start while busy ignored.

Source files
------------

// File: rtl/wave_sequencer_pkg.sv
// Shared types and defaults for the DDS waveform run controller.
package wave_sequencer_pkg;

   localparam int DEF_ACC_W   = 32;
   localparam int DEF_PHASE_W = 8;
   localparam int DEF_CNT_W   = 16;
   localparam int DEF_ROM_LAT = 2;

   typedef logic [1:0] wave_t;

   localparam wave_t WAVE_TRI     = 2'b00;
   localparam wave_t WAVE_TRI_REV = 2'b01;
   localparam wave_t WAVE_SQUARE  = 2'b10;
   localparam wave_t WAVE_COS     = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   function automatic logic is_running(input state_t s);
      return (s == ST_PRIME) || (s == ST_RUN);
   endfunction

endpackage

// File: rtl/wave_sequencer_if.sv
// Configuration handshake and ROM-side bus of the waveform sequencer.
interface wave_sequencer_if
   import wave_sequencer_pkg::*;
#(
   parameter int ACC_W   = DEF_ACC_W,
   parameter int PHASE_W = DEF_PHASE_W,
   parameter int CNT_W   = DEF_CNT_W
) ();

   logic               cfg_valid;
   logic               cfg_ready;
   logic [ACC_W-1:0]   cfg_fword;
   wave_t              cfg_select;
   logic [CNT_W-1:0]   cfg_cycles;

   logic               rom_en;
   wave_t              rom_select;
   logic [PHASE_W-1:0] rom_phase;
   logic               amp_valid;

   modport master (
      output cfg_valid, cfg_fword, cfg_select, cfg_cycles,
      input  cfg_ready, rom_en, rom_select, rom_phase, amp_valid
   );

   modport slave (
      input  cfg_valid, cfg_fword, cfg_select, cfg_cycles,
      output cfg_ready, rom_en, rom_select, rom_phase, amp_valid
   );

endinterface

// File: rtl/wave_sequencer_phase_accum.sv
// Phase accumulator with carry-out wrap flag; holds when advance is low.
module phase_accum #(
   parameter int ACC_W = 32
) (
   input  logic             clk,
   input  logic             en,
   input  logic             clear,
   input  logic             advance,
   input  logic [ACC_W-1:0] fword,
   output logic [ACC_W-1:0] acc,
   output logic             wrap
);

   logic [ACC_W:0] sum;

   assign sum  = {1'b0, acc} + {1'b0, fword};
   assign wrap = advance & sum[ACC_W];

   always_ff @(posedge clk or negedge en) begin
      if (!en) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (advance) begin
         acc <= sum[ACC_W-1:0];
      end
   end

endmodule

// File: rtl/wave_sequencer.sv
// DDS run controller: drives ROM phase/select/enable, applies new config only at phase wrap.
module wave_sequencer
   import wave_sequencer_pkg::*;
#(
   parameter int ACC_W   = DEF_ACC_W,
   parameter int PHASE_W = DEF_PHASE_W,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int ROM_LAT = DEF_ROM_LAT
) (
   input  logic              clk,
   input  logic              en,
   input  logic              start,
   input  logic              stop,
   output logic              busy,
   output logic              done,
   wave_sequencer_if.slave   bus
);

   localparam int               LAT_W    = $clog2(ROM_LAT + 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LAT - 1);

   state_t             state, state_nxt;
   logic [ACC_W-1:0]   act_fword, shd_fword, acc;
   wave_t              act_sel, shd_sel;
   logic [CNT_W-1:0]   act_cycles, shd_cycles, remaining;
   logic               pending, pending_nxt, stop_req;
   logic               rom_en_q, rom_en_d, done_d, cfg_ready_q, cfg_ready_d;
   logic [LAT_W-1:0]   lat_cnt;
   logic [ROM_LAT-1:0] vpipe;
   logic               wrap, xfer, apply, sel_change, last_period, fword_zero;

   assign xfer        = bus.cfg_valid && cfg_ready_q;
   assign apply       = (state == ST_RUN) && wrap && pending;
   assign sel_change  = apply && (shd_sel != act_sel);
   assign last_period = (remaining == CNT_W'(1));
   assign fword_zero  = (act_fword == '0);

   phase_accum #(.ACC_W(ACC_W)) u_accum (
      .clk     (clk),
      .en      (en),
      .clear   ((state == ST_IDLE) && start),
      .advance (is_running(state)),
      .fword   (act_fword),
      .acc     (acc),
      .wrap    (wrap)
   );

   always_ff @(posedge clk or negedge en) begin
      if (!en) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_PRIME;
         ST_PRIME: begin
            if (stop_req && fword_zero)  state_nxt = ST_DRAIN;
            else if (lat_cnt == LAT_LAST) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if ((wrap && (stop_req || last_period)) || (stop_req && fword_zero))
               state_nxt = ST_DRAIN;
         end
         ST_DRAIN: if (lat_cnt == LAT_LAST) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // An unapplied shadow config is discarded when the run ends.
   always_comb begin
      rom_en_d    = (state_nxt != ST_IDLE);
      done_d      = (state == ST_DRAIN) && (state_nxt == ST_IDLE);
      pending_nxt = pending;
      if (state_nxt == ST_IDLE)               pending_nxt = 1'b0;
      else if (apply)                         pending_nxt = 1'b0;
      else if (xfer && is_running(state))     pending_nxt = 1'b1;
      cfg_ready_d = (state_nxt == ST_IDLE) || (is_running(state_nxt) && !pending_nxt);
   end

   always_ff @(posedge clk or negedge en) begin
      if (!en) begin
         rom_en_q    <= 1'b0;
         done        <= 1'b0;
         cfg_ready_q <= 1'b0;
         pending     <= 1'b0;
         stop_req    <= 1'b0;
         lat_cnt     <= '0;
         vpipe       <= '0;
         remaining   <= '0;
         act_fword   <= '0;
         act_sel     <= WAVE_TRI;
         act_cycles  <= '0;
         shd_fword   <= '0;
         shd_sel     <= WAVE_TRI;
         shd_cycles  <= '0;
      end else begin
         rom_en_q    <= rom_en_d;
         done        <= done_d;
         cfg_ready_q <= cfg_ready_d;
         pending     <= pending_nxt;
         // A select change restarts the ROM latency window.
         vpipe       <= sel_change ? '0 : {vpipe[ROM_LAT-2:0], rom_en_q};

         if (state == ST_IDLE)                 stop_req <= 1'b0;
         else if (stop && is_running(state))   stop_req <= 1'b1;

         if (state_nxt != state)                            lat_cnt <= '0;
         else if (state == ST_PRIME || state == ST_DRAIN)   lat_cnt <= lat_cnt + LAT_W'(1);

         if (xfer && state == ST_IDLE) begin
            act_fword  <= bus.cfg_fword;
            act_sel    <= bus.cfg_select;
            act_cycles <= bus.cfg_cycles;
         end else if (apply) begin
            act_fword  <= shd_fword;
            act_sel    <= shd_sel;
            act_cycles <= shd_cycles;
         end
         if (xfer && is_running(state)) begin
            shd_fword  <= bus.cfg_fword;
            shd_sel    <= bus.cfg_select;
            shd_cycles <= bus.cfg_cycles;
         end

         if (state == ST_IDLE && start)
            remaining <= xfer ? bus.cfg_cycles : act_cycles;
         else if (state == ST_RUN && wrap && remaining != '0)
            remaining <= remaining - CNT_W'(1);
      end
   end

   assign bus.cfg_ready  = cfg_ready_q;
   assign bus.rom_en     = rom_en_q;
   assign bus.rom_select = act_sel;
   assign bus.rom_phase  = acc[ACC_W-1 -: PHASE_W];
   assign bus.amp_valid  = vpipe[ROM_LAT-1] & rom_en_q;
   assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer with hand-computed expectations.
module tb_wave_sequencer;
   import wave_sequencer_pkg::*;

   logic clk = 1'b0;
   logic en, start, stop, busy, done;
   int   n_cmp = 0;
   int   n_bad = 0;

   wave_sequencer_if bus();

   wave_sequencer dut (
      .clk   (clk),
      .en    (en),
      .start (start),
      .stop  (stop),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic [31:0] fw, input wave_t sel, input logic [15:0] cyc);
      bus.cfg_valid  = 1'b1;
      bus.cfg_fword  = fw;
      bus.cfg_select = sel;
      bus.cfg_cycles = cyc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      en = 1'b0; start = 1'b0; stop = 1'b0;
      bus.cfg_valid = 1'b0; bus.cfg_fword = '0; bus.cfg_select = '0; bus.cfg_cycles = '0;
      #12;
      chk("rst_rom_en",    {31'd0, bus.rom_en},    32'd0);
      chk("rst_cfg_ready", {31'd0, bus.cfg_ready}, 32'd0);
      chk("rst_busy",      {31'd0, busy},          32'd0);
      en = 1'b1;
      tick(1);
      chk("idle_cfg_ready", {31'd0, bus.cfg_ready}, 32'd1);

      // Burst: two periods of 256 steps, cosine
      offer(32'h0100_0000, WAVE_COS, 16'd2); start = 1'b1;
      tick(1);
      bus.cfg_valid = 1'b0; start = 1'b0;
      chk("b_busy",    {31'd0, busy},          32'd1);
      chk("b_rom_en",  {31'd0, bus.rom_en},    32'd1);
      chk("b_sel",     {30'd0, bus.rom_select}, 32'd3);
      chk("b_phase0",  {24'd0, bus.rom_phase}, 32'h00);
      chk("b_amp_t0",  {31'd0, bus.amp_valid}, 32'd0);
      tick(1);
      chk("b_amp_t1",  {31'd0, bus.amp_valid}, 32'd0);
      chk("b_phase1",  {24'd0, bus.rom_phase}, 32'h01);
      tick(1);
      chk("b_amp_t2",  {31'd0, bus.amp_valid}, 32'd1);
      tick(254);
      chk("b_wrap1_phase", {24'd0, bus.rom_phase}, 32'h00);
      chk("b_wrap1_busy",  {31'd0, busy},          32'd1);
      tick(255);
      chk("b_phase_ff", {24'd0, bus.rom_phase}, 32'hFF);
      tick(1);
      chk("b_drain_busy",  {31'd0, busy},          32'd1);
      chk("b_drain_ready", {31'd0, bus.cfg_ready}, 32'd0);
      chk("b_drain_phase", {24'd0, bus.rom_phase}, 32'h00);
      tick(1);
      chk("b_drain_done0", {31'd0, done},          32'd0);
      chk("b_drain_hold",  {24'd0, bus.rom_phase}, 32'h00);
      tick(1);
      chk("b_done",        {31'd0, done},          32'd1);
      chk("b_idle_busy",   {31'd0, busy},          32'd0);
      chk("b_idle_rom_en", {31'd0, bus.rom_en},    32'd0);
      chk("b_idle_amp",    {31'd0, bus.amp_valid}, 32'd0);
      tick(1);
      chk("b_done_pulse",  {31'd0, done},          32'd0);

      // Glitch-free select change, continuous run
      offer(32'h0100_0000, WAVE_TRI, 16'd0); start = 1'b1;
      tick(1);
      bus.cfg_valid = 1'b0; start = 1'b0;
      tick(16);
      chk("g_phase10", {24'd0, bus.rom_phase}, 32'h10);
      offer(32'h0100_0000, WAVE_SQUARE, 16'd0);
      tick(1);
      bus.cfg_valid = 1'b0;
      chk("g_ready_low", {31'd0, bus.cfg_ready},  32'd0);
      chk("g_sel_old",   {30'd0, bus.rom_select}, 32'd0);
      tick(238);
      chk("g_phase_ff",  {24'd0, bus.rom_phase},  32'hFF);
      chk("g_sel_hold",  {30'd0, bus.rom_select}, 32'd0);
      chk("g_amp_pre",   {31'd0, bus.amp_valid},  32'd1);
      tick(1);
      chk("g_sel_new",   {30'd0, bus.rom_select}, 32'd2);
      chk("g_amp_low0",  {31'd0, bus.amp_valid},  32'd0);
      chk("g_ready_back",{31'd0, bus.cfg_ready},  32'd1);
      chk("g_still_run", {31'd0, busy},           32'd1);
      tick(1);
      chk("g_amp_low1",  {31'd0, bus.amp_valid},  32'd0);
      tick(1);
      chk("g_amp_back",  {31'd0, bus.amp_valid},  32'd1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("g_start_ignored", {24'd0, bus.rom_phase}, 32'h03);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      tick(251);
      chk("g_stop_wait", {31'd0, bus.rom_en}, 32'd1);
      chk("g_stop_ff",   {24'd0, bus.rom_phase}, 32'hFF);
      tick(1);
      chk("g_drain", {31'd0, bus.cfg_ready}, 32'd0);
      tick(2);
      chk("g_done",  {31'd0, done}, 32'd1);

      // Continuous + stop at phase 0x20
      offer(32'h0400_0000, WAVE_TRI_REV, 16'd0); start = 1'b1;
      tick(1);
      bus.cfg_valid = 1'b0; start = 1'b0;
      tick(8);
      chk("c_phase20", {24'd0, bus.rom_phase}, 32'h20);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      tick(54);
      chk("c_phase_fc", {24'd0, bus.rom_phase}, 32'hFC);
      chk("c_run_ready",{31'd0, bus.cfg_ready}, 32'd1);
      tick(1);
      chk("c_drain_ready", {31'd0, bus.cfg_ready}, 32'd0);
      chk("c_drain_phase", {24'd0, bus.rom_phase}, 32'h00);
      tick(1);
      chk("c_done0", {31'd0, done}, 32'd0);
      tick(1);
      chk("c_done",  {31'd0, done}, 32'd1);
      chk("c_idle",  {31'd0, busy}, 32'd0);

      // Config and start in the same cycle
      offer(32'h1000_0000, WAVE_SQUARE, 16'd1); start = 1'b1;
      tick(1);
      bus.cfg_valid = 1'b0; start = 1'b0;
      chk("s_sel",    {30'd0, bus.rom_select}, 32'd2);
      tick(1);
      chk("s_fword",  {24'd0, bus.rom_phase},  32'h10);
      tick(14);
      chk("s_phase_f0", {24'd0, bus.rom_phase}, 32'hF0);
      tick(1);
      chk("s_drain", {31'd0, bus.cfg_ready}, 32'd0);
      tick(2);
      chk("s_done",  {31'd0, done}, 32'd1);

      // Zero tuning word: stop cannot wait for a wrap
      offer(32'h0000_0000, WAVE_TRI, 16'd0); start = 1'b1;
      tick(1);
      bus.cfg_valid = 1'b0; start = 1'b0;
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      chk("z_prime_ready", {31'd0, bus.cfg_ready}, 32'd1);
      tick(1);
      chk("z_drain_ready", {31'd0, bus.cfg_ready}, 32'd0);
      chk("z_phase",       {24'd0, bus.rom_phase}, 32'h00);
      tick(1);
      chk("z_done0", {31'd0, done}, 32'd0);
      tick(1);
      chk("z_done",  {31'd0, done}, 32'd1);

      // Asynchronous reset mid-run
      offer(32'h0100_0000, WAVE_COS, 16'd0); start = 1'b1;
      tick(1);
      bus.cfg_valid = 1'b0; start = 1'b0;
      tick(20);
      chk("r_phase14", {24'd0, bus.rom_phase}, 32'h14);
      en = 1'b0;
      #1;
      chk("r_rom_en", {31'd0, bus.rom_en},     32'd0);
      chk("r_amp",    {31'd0, bus.amp_valid},  32'd0);
      chk("r_phase",  {24'd0, bus.rom_phase},  32'h00);
      chk("r_sel",    {30'd0, bus.rom_select}, 32'd0);
      chk("r_busy",   {31'd0, busy},           32'd0);
      chk("r_ready",  {31'd0, bus.cfg_ready},  32'd0);
      #2;
      en = 1'b1;
      tick(1);
      chk("r_ready_after", {31'd0, bus.cfg_ready}, 32'd1);
      chk("r_busy_after",  {31'd0, busy},          32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
